clk_phase_gen: RTL and testbench
================================

# clk_phase_gen

- Parametrised N-phase round-robin clock distributor: each high phase of `clk_in` is steered to one of `NUM_PHASES` outputs in rotation.
- Each phase owns a programmable number of consecutive `clk_in` cycles (a slot); outputs are mutually exclusive and never overlap.
- Generalises the two-output alternating clock generator with a runtime slot length, a per-phase mask, a run enable and frame status.
- Feeds multi-phase datapaths such as interleaved samplers and time-multiplexed register banks.

## Interface
- `NUM_PHASES`, default 4: number of output phases; must be ≥ 2.
- `LEN_W`, default 4: width of `slot_len`.
- `clk_in`  input  1  source clock; the outputs are gated copies of its high phase.
- `reset`  input  1  asynchronous, active-high.
- `en`  input  1  run enable; sampled on the falling edge of `clk_in`.
- `slot_len`  input  LEN_W  number of `clk_in` cycles per slot; 0 is treated as 1; sampled on the falling edge.
- `phase_mask`  input  NUM_PHASES  bit i = 1 allows `clk_out[i]` to pulse; sampled on the falling edge.
- `clk_out`  output  NUM_PHASES  gated phase clocks.
- `slot_idx`  output  $clog2(NUM_PHASES)  index of the slot that owns the current/next high phase.
- `frame_sync`  output  1  high for the `clk_in` cycle that starts slot 0.

## Operation
- **State, all updated on the falling edge of `clk_in`:**
  - `started` (1 bit).
  - `slot` (slot index).
  - `cnt` (LEN_W bits).
  - `sel` (NUM_PHASES bits, one-hot or zero).
  - `frame_sync`.
- **Output function:** `clk_out[i] = clk_in & sel[i]`.
  - `sel` changes only while `clk_in` is low, so outputs are glitch-free.
  - Each pulse equals exactly one `clk_in` high phase.
- **Effective length:** `L = (slot_len == 0) ? 1 : slot_len`.
- **Rules at each falling edge (reset low):**
  - **`en == 0`:**
    - `sel <= 0` and `frame_sync <= 0`.
    - `slot`, `cnt` and `started` hold.
  - **`en == 1` and `started == 0`:**
    - `started <= 1`, `slot <= 0`, `cnt <= 0`.
    - `sel <= onehot(0) & phase_mask`.
    - `frame_sync <= 1`.
  - **`en == 1` and `started == 1`:**
    - If `cnt >= L-1`:
      - `cnt <= 0`.
      - `slot <= (slot == NUM_PHASES-1) ? 0 : slot+1`.
    - Otherwise `cnt <= cnt+1`.
    - `sel <= onehot(new slot) & phase_mask`.
    - `frame_sync <= (new slot == 0 && new cnt == 0)`.
- **Masked phases:** a masked phase still consumes its slot; the output stays low, so the frame period is always `NUM_PHASES*L` cycles.
- **Changing `slot_len`:**
  - The `>=` compare ends the current slot immediately if `slot_len` shrinks below `cnt+1`.
  - Growing `slot_len` extends the current slot.
- **Resume after `en` low:** continues from the held `slot`/`cnt`, advancing by one step on the first enabled falling edge.
- **`slot_idx`** reflects the `slot` register.

## Timing
- **Reset values:**
  - `clk_out = 0`, `slot_idx = 0`, `frame_sync = 0`.
  - `started = 0`, `cnt = 0`, `sel = 0`.
- **First pulse after reset release:** occurs on the first `clk_in` high phase that follows a falling edge with `en = 1`, on `clk_out[0]` (if unmasked).
- **Input latency:** changes to `en`, `phase_mask` and `slot_len` affect the high phase immediately following the next falling edge.
- **Reset asserted mid-operation:**
  - `sel` clears asynchronously; a pulse in progress is truncated.
  - The state returns to its reset values, and the sequence restarts at slot 0.
- **Exclusivity:** at most one `clk_out` bit is high at any instant.

## Test plan
- **Basic rotation:** `NUM_PHASES=4`, `slot_len=1`, `mask=4'b1111`, `en=1` → `clk_out[0..3]` pulse in order 0,1,2,3,0,…, one pulse each per 4 `clk_in` cycles; `frame_sync` is high every 4th cycle, aligned with the `clk_out[0]` pulse.
- **Burst slots:** `slot_len=3` → each output gives 3 consecutive pulses; frame = 12 cycles; `slot_idx` steps 0→1→2→3 every 3 cycles. Repeat with `slot_len=0` → behaves as `slot_len=1`.
- **Masking:** `mask=4'b0101`, `slot_len=2` → only `clk_out[0]` and `clk_out[2]` pulse (2 pulses each); cycles in slots 1 and 3 show all outputs low; the frame stays 8 cycles.
- **Enable gap:** deassert `en` for 2 cycles during `slot=2`, `cnt=0` (`slot_len=2`) → no pulses for 2 cycles, `slot_idx` holds at 2; after re-enable one `clk_out[2]` pulse, then slot 3.
- **Slot-length shrink:** `slot_len` changes 4→2 while `cnt=2` → the current slot ends at the next falling edge; subsequent slots are 2 cycles.
- **Reset mid-pulse:** assert `reset` while `clk_out[1]` is high → it drops immediately, all outputs are 0 and `slot_idx=0`; after release the first pulse appears on `clk_out[0]`.

Source files
------------

// File: rtl/clk_phase_gen_if.sv
// Control and output bundle for the N-phase round-robin clock distributor.
// The master drives the run controls; the slave (the generator) drives the phase clocks and status.
interface clk_phase_gen_if #(
  parameter int NUM_PHASES = 4,
  parameter int LEN_W      = 4
);
  localparam int SLOT_W = $clog2(NUM_PHASES);

  logic                  en;
  logic [LEN_W-1:0]      slot_len;
  logic [NUM_PHASES-1:0] phase_mask;
  logic [NUM_PHASES-1:0] clk_out;
  logic [SLOT_W-1:0]     slot_idx;
  logic                  frame_sync;

  modport master (
    output en, slot_len, phase_mask,
    input  clk_out, slot_idx, frame_sync
  );

  modport slave (
    input  en, slot_len, phase_mask,
    output clk_out, slot_idx, frame_sync
  );
endinterface

// File: rtl/clk_phase_gen.sv
// N-phase round-robin clock distributor: each clk_in high phase is steered to one output,
// with every phase owning slot_len consecutive cycles. All state moves on the falling edge.
module clk_phase_gen #(
  parameter int NUM_PHASES = 4,
  parameter int LEN_W      = 4
) (
  input logic           clk_in,
  input logic           reset,
  clk_phase_gen_if.slave bus
);
  localparam int SLOT_W = $clog2(NUM_PHASES);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_next;
  logic [SLOT_W-1:0]     slot, slot_next;
  logic [LEN_W-1:0]      cnt, cnt_next;
  logic [LEN_W-1:0]      eff_len;
  logic [NUM_PHASES-1:0] sel, sel_next;
  logic                  frame_sync_q, frame_sync_next;

  // Falling-edge update keeps sel stable for the whole high phase, so the gated outputs cannot glitch.
  always_ff @(negedge clk_in or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      slot         <= '0;
      cnt          <= '0;
      sel          <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      state        <= state_next;
      slot         <= slot_next;
      cnt          <= cnt_next;
      sel          <= sel_next;
      frame_sync_q <= frame_sync_next;
    end
  end

  always_comb begin
    eff_len         = (bus.slot_len == '0) ? LEN_W'(1) : bus.slot_len;
    state_next      = state;
    slot_next       = slot;
    cnt_next        = cnt;
    sel_next        = '0;
    frame_sync_next = 1'b0;
    if (bus.en) begin
      if (state == IDLE) begin
        state_next      = RUN;
        slot_next       = '0;
        cnt_next        = '0;
        frame_sync_next = 1'b1;
      end else begin
        // >= rather than == so a shrinking slot_len closes an over-long slot right away.
        if (cnt >= eff_len - LEN_W'(1)) begin
          cnt_next  = '0;
          slot_next = (slot == SLOT_W'(NUM_PHASES - 1)) ? '0 : slot + SLOT_W'(1);
        end else begin
          cnt_next = cnt + LEN_W'(1);
        end
        frame_sync_next = (slot_next == '0) && (cnt_next == '0);
      end
      sel_next = (NUM_PHASES'(1) << slot_next) & bus.phase_mask;
    end
  end

  assign bus.clk_out    = {NUM_PHASES{clk_in}} & sel;
  assign bus.slot_idx   = slot;
  assign bus.frame_sync = frame_sync_q;
endmodule

// File: tb/tb_clk_phase_gen.sv
// Directed bench for clk_phase_gen: rotation, burst slots, masking, enable gaps,
// slot-length shrink and asynchronous reset mid-pulse, sampled mid high phase.
module tb_clk_phase_gen;
  localparam int NP = 4;
  localparam int LW = 4;

  logic clk_in;
  logic reset;
  int   n_compared;
  int   n_mismatched;

  clk_phase_gen_if #(.NUM_PHASES(NP), .LEN_W(LW)) bus ();

  clk_phase_gen #(.NUM_PHASES(NP), .LEN_W(LW)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus.slave)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  // Holds reset across one falling edge and releases it inside a high phase with en low.
  task automatic do_reset();
    @(posedge clk_in);
    #1 reset = 1'b1;
    bus.en = 1'b0;
    @(posedge clk_in);
    #1 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.en         = 1'b0;
    bus.slot_len   = 4'd1;
    bus.phase_mask = 4'b1111;
    @(posedge clk_in);
    #2;
    if (bus.clk_out !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL reset_clk_out got %b want 0000", bus.clk_out);
    end
    n_compared++;
    if (bus.slot_idx !== 2'd0 || bus.frame_sync !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_status got slot %0d fs %b want slot 0 fs 0", bus.slot_idx, bus.frame_sync);
    end
    n_compared++;
    reset = 1'b0;
    @(posedge clk_in);
    #2;
    if (bus.clk_out !== 4'b0000) begin
      n_mismatched++;
      $display("[TB] FAIL idle_no_pulse got %b want 0000", bus.clk_out);
    end
    n_compared++;
  endtask

  // Runs 'steps' high phases at a fixed slot length and mask, checking outputs against the rotation.
  task automatic test_rotation(input logic [3:0] len, input logic [3:0] mask, input int steps, input string name);
    int eff;
    logic [1:0] exp_slot;
    logic [3:0] exp_out;
    logic exp_fs;
    eff = (len == 0) ? 1 : int'(len);
    do_reset();
    bus.slot_len   = len;
    bus.phase_mask = mask;
    bus.en         = 1'b1;
    for (int k = 0; k < steps; k++) begin
      @(posedge clk_in);
      #2;
      exp_slot = 2'((k / eff) % NP);
      exp_out  = (4'(1) << exp_slot) & mask;
      exp_fs   = ((k % (NP * eff)) == 0);
      if (bus.clk_out !== exp_out || bus.slot_idx !== exp_slot || bus.frame_sync !== exp_fs) begin
        n_mismatched++;
        $display("[TB] FAIL %s step %0d got out %b slot %0d fs %b want out %b slot %0d fs %b",
                 name, k, bus.clk_out, bus.slot_idx, bus.frame_sync, exp_out, exp_slot, exp_fs);
      end
      n_compared++;
      @(negedge clk_in);
      #2;
      if (bus.clk_out !== 4'b0000) begin
        n_mismatched++;
        $display("[TB] FAIL %s low_phase step %0d got %b want 0000", name, k, bus.clk_out);
      end
      n_compared++;
    end
  endtask

  task automatic test_enable_gap();
    logic [3:0] exp_out [0:8];
    logic [1:0] exp_slot [0:8];
    exp_out  = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b1000};
    exp_slot = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd3};
    do_reset();
    bus.slot_len   = 4'd2;
    bus.phase_mask = 4'b1111;
    bus.en         = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk_in);
      #2;
      if (bus.clk_out !== exp_out[k] || bus.slot_idx !== exp_slot[k]) begin
        n_mismatched++;
        $display("[TB] FAIL enable_gap step %0d got out %b slot %0d want out %b slot %0d",
                 k, bus.clk_out, bus.slot_idx, exp_out[k], exp_slot[k]);
      end
      n_compared++;
      if (k == 4) bus.en = 1'b0;
      if (k == 6) bus.en = 1'b1;
    end
  endtask

  task automatic test_shrink();
    logic [3:0] exp_out [0:9];
    logic [1:0] exp_slot [0:9];
    logic       exp_fs [0:9];
    exp_out  = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000, 4'b0001};
    exp_slot = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
    exp_fs   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    bus.slot_len   = 4'd4;
    bus.phase_mask = 4'b1111;
    bus.en         = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk_in);
      #2;
      if (bus.clk_out !== exp_out[k] || bus.slot_idx !== exp_slot[k] || bus.frame_sync !== exp_fs[k]) begin
        n_mismatched++;
        $display("[TB] FAIL shrink step %0d got out %b slot %0d fs %b want out %b slot %0d fs %b",
                 k, bus.clk_out, bus.slot_idx, bus.frame_sync, exp_out[k], exp_slot[k], exp_fs[k]);
      end
      n_compared++;
      if (k == 2) bus.slot_len = 4'd2;
    end
  endtask

  task automatic test_reset_mid_pulse();
    do_reset();
    bus.slot_len   = 4'd1;
    bus.phase_mask = 4'b1111;
    bus.en         = 1'b1;
    @(posedge clk_in);
    @(posedge clk_in);
    #2;
    if (bus.clk_out !== 4'b0010) begin
      n_mismatched++;
      $display("[TB] FAIL pre_reset_pulse got %b want 0010", bus.clk_out);
    end
    n_compared++;
    #1 reset = 1'b1;
    #1;
    if (bus.clk_out !== 4'b0000 || bus.slot_idx !== 2'd0 || bus.frame_sync !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_truncate got out %b slot %0d fs %b want out 0000 slot 0 fs 0",
               bus.clk_out, bus.slot_idx, bus.frame_sync);
    end
    n_compared++;
    @(posedge clk_in);
    #1 reset = 1'b0;
    @(posedge clk_in);
    #2;
    if (bus.clk_out !== 4'b0001 || bus.frame_sync !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL restart_first got out %b fs %b want out 0001 fs 1", bus.clk_out, bus.frame_sync);
    end
    n_compared++;
    @(posedge clk_in);
    #2;
    if (bus.clk_out !== 4'b0010 || bus.slot_idx !== 2'd1) begin
      n_mismatched++;
      $display("[TB] FAIL restart_second got out %b slot %0d want out 0010 slot 1", bus.clk_out, bus.slot_idx);
    end
    n_compared++;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    test_reset();
    test_rotation(4'd1, 4'b1111, 8, "rotation");
    test_rotation(4'd3, 4'b1111, 14, "burst3");
    test_rotation(4'd0, 4'b1111, 8, "len0");
    test_rotation(4'd2, 4'b0101, 16, "mask");
    test_enable_gap();
    test_shrink();
    test_reset_mid_pulse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
